// File: rtl/conv_weight_loader.sv
// conv_weight_loader
// Fills the convolution weight memory from a byte stream before inference
// starts. Eighteen bytes are collected into one 9-tap kernel word of 16-bit
// little-endian parameters. Each finished word is written once through the
// memory's second port, at consecutive addresses starting from 0.
//
// Ports:
//   clk       system clock, everything on the rising edge
//   rst_n     synchronous active-low reset
//   start     one-cycle request to begin a full load (only honoured when idle)
//   in_data   stream byte
//   in_valid  in_data is valid
//   in_ready  loader accepts a byte this cycle (registered)
//   wr_en     write strobe for the weight memory write port
//   wr_addr   write address
//   wr_data   write word, tap k in bits [16k+15:16k]
//   busy      high while receiving or writing
//   done      one-cycle pulse once the last word has been written
//   word_cnt  number of words written in the current load
module conv_weight_loader #(
    parameter int WORDS   = 2576,
    parameter int PARSIZE = 16,
    parameter int TAPS    = 9,
    parameter int ADDR_W  = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [TAPS*PARSIZE-1:0]   wr_data,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_W-1:0]         word_cnt
);

    localparam int DATA_W = TAPS * PARSIZE;
    localparam int NBYTES = DATA_W / 8;
    localparam int IDX_W  = $clog2(NBYTES);
    localparam logic [IDX_W-1:0]  LAST_BYTE = IDX_W'(NBYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
    logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
    logic [DATA_W-1:0]   asm_q, asm_d;

    // Next-state and next-output logic. All outputs are computed from the
    // state we are about to enter, so in_ready never depends on in_valid in
    // the same cycle. The write word is taken from the assembly register
    // including the byte arriving on the last transfer, so wr_en follows that
    // transfer by exactly one cycle. done is raised when leaving DONE, which
    // keeps busy high through the DONE cycle and drops it together with done.
    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RECV;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                    byte_idx_d = '0;
                    word_cnt_d = '0;
                end
            end
            RECV: begin
                if (in_valid && in_ready_q) begin
                    asm_d[8*byte_idx_q +: 8] = in_data;
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d    = WRITE;
                        in_ready_d = 1'b0;
                        wr_en_d    = 1'b1;
                        wr_addr_d  = word_cnt_q;
                        wr_data_d  = asm_d;
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end
                end
            end
            WRITE: begin
                word_cnt_d = word_cnt_q + ADDR_W'(1);
                byte_idx_d = '0;
                if (word_cnt_q == LAST_WORD) begin
                    state_d = DONE;
                end else begin
                    state_d    = RECV;
                    in_ready_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset. Resetting in the
    // middle of a word throws the partial word away without writing it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_conv_weight_loader.sv
// tb_conv_weight_loader
// Drives two loaders from one shared byte stream: dut0 with the full
// 2576-word size and dut1 sized to a single word. Writes from dut0 are
// matched against a queue of expected (address, word) pairs, filled as the
// final byte of each word is driven.
module tb_conv_weight_loader;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 144;
    localparam int NBYTES     = 18;
    localparam int FULL_WORDS = 2576;

    typedef logic [191:0] chk_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [7:0]         in_data;
    logic               in_valid;

    logic               in_ready0, wr_en0, busy0, done0;
    logic [ADDR_W-1:0]  wr_addr0, word_cnt0;
    logic [DATA_W-1:0]  wr_data0;

    logic               in_ready1, wr_en1, busy1, done1;
    logic [ADDR_W-1:0]  wr_addr1, word_cnt1;
    logic [DATA_W-1:0]  wr_data1;

    logic               use_small;
    logic               cur_ready;

    int                 tests_run = 0;
    int                 tests_failed = 0;
    bit                 abort = 1'b0;
    bit                 mon0_en = 1'b0;
    bit                 mon1_en = 1'b0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    int                 cyc = 0;
    int                 wr_cnt0 = 0;
    int                 done_cnt0 = 0;
    int                 wr_cnt1 = 0;
    int                 done_cnt1 = 0;
    int                 wr_cyc1 = 0;
    int                 done_cyc1 = 0;
    logic [ADDR_W-1:0]  wr_addr1_s = '0;
    logic [DATA_W-1:0]  wr_data1_s = '0;
    logic               busy_at_done1 = 1'b0;
    logic               busy_before_done1 = 1'b0;
    logic               prev_busy1 = 1'b0;

    conv_weight_loader dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready0),
        .wr_en    (wr_en0),
        .wr_addr  (wr_addr0),
        .wr_data  (wr_data0),
        .busy     (busy0),
        .done     (done0),
        .word_cnt (word_cnt0)
    );

    conv_weight_loader #(.WORDS(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready1),
        .wr_en    (wr_en1),
        .wr_addr  (wr_addr1),
        .wr_data  (wr_data1),
        .busy     (busy1),
        .done     (done1),
        .word_cnt (word_cnt1)
    );

    assign cur_ready = use_small ? in_ready1 : in_ready0;

    // 10-unit clock period; inputs change and outputs are sampled on the
    // falling edge.
    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch counts and reports a failure.
    task automatic checkOutput(input string tag, input chk_t observed, input chk_t expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Offers one byte and returns on the falling edge after it was accepted.
    // A loader that never raises in_ready ends the stream early.
    task automatic applyStimulus(input logic [7:0] b);
        int n;
        if (abort) return;
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!cur_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cur_ready) begin
            checkOutput("in_ready_timeout", chk_t'(cur_ready), chk_t'(1'b1));
            abort    = 1'b1;
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
    endtask

    // Streams one 18-byte word, optionally with random idle gaps, a 10-cycle
    // stall after byte stall_after, and a start pulse after byte start_after.
    task automatic sendWord(input logic [DATA_W-1:0] word, input logic [ADDR_W-1:0] addr,
                            input bit gaps, input int stall_after, input int start_after);
        for (int b = 0; b < NBYTES; b++) begin
            if (stall_after >= 0 && b == stall_after + 1) begin
                in_valid = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    checkOutput("stall_quiet", chk_t'({wr_en0, word_cnt0}), chk_t'({1'b0, addr}));
                end
            end
            if (start_after >= 0 && b == start_after + 1) begin
                in_valid = 1'b0;
                start    = 1'b1;
                @(negedge clk);
                start = 1'b0;
                checkOutput("start_ignored", chk_t'({busy0, in_ready0, word_cnt0}),
                            chk_t'({1'b1, 1'b1, addr}));
            end
            if (gaps && $urandom_range(15) == 0) begin
                in_valid = 1'b0;
                repeat (int'($urandom_range(3, 1))) @(negedge clk);
            end
            if (b == NBYTES - 1) exp_q.push_back({addr, word});
            applyStimulus(word[8*b +: 8]);
        end
    endtask

    task automatic randomWord(output logic [DATA_W-1:0] word);
        for (int b = 0; b < NBYTES; b++) word[8*b +: 8] = 8'($urandom_range(255));
    endtask

    // Watches both loaders on every falling edge: dut0 writes are popped
    // from the expectation queue, dut1 activity is recorded for later checks.
    task automatic monitorLoop();
        logic [ADDR_W+DATA_W-1:0] exp;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon0_en) begin
                if (wr_en0) begin
                    wr_cnt0++;
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_write", chk_t'(wr_en0), chk_t'(1'b0));
                    end else begin
                        exp = exp_q.pop_front();
                        checkOutput("wr_addr", chk_t'(wr_addr0), chk_t'(exp[ADDR_W+DATA_W-1:DATA_W]));
                        checkOutput("wr_data", chk_t'(wr_data0), chk_t'(exp[DATA_W-1:0]));
                    end
                end
                if (done0) done_cnt0++;
            end
            if (mon1_en) begin
                if (wr_en1) begin
                    wr_cnt1++;
                    wr_cyc1    = cyc;
                    wr_addr1_s = wr_addr1;
                    wr_data1_s = wr_data1;
                end
                if (done1) begin
                    done_cnt1++;
                    done_cyc1         = cyc;
                    busy_at_done1     = busy1;
                    busy_before_done1 = prev_busy1;
                end
                prev_busy1 = busy1;
            end
        end
    endtask

    // Hard stop if something keeps the sequence from reaching its end.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence: reset/idle, single-word load on dut1, full random
    // load with stall and stray start on dut0, then reset in the middle of
    // a word followed by a fresh load.
    initial begin
        logic [DATA_W-1:0] word;
        logic [DATA_W-1:0] small_word;
        int base_wr;
        int base_done;

        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        use_small = 1'b0;
        small_word = '0;

        fork
            monitorLoop();
        join_none

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle_outputs",
                        chk_t'({in_ready0, wr_en0, busy0, done0, wr_addr0, wr_data0, word_cnt0}), '0);
        end

        $display("[TB] single word load");
        use_small = 1'b1;
        mon1_en   = 1'b1;
        start     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h01;
        @(negedge clk);
        start = 1'b0;
        checkOutput("small_ready_after_start", chk_t'({busy1, in_ready1}), chk_t'(2'b11));
        for (int b = 0; b < NBYTES; b++) begin
            small_word[8*b +: 8] = 8'(b + 1);
            applyStimulus(8'(b + 1));
        end
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("small_write_count", chk_t'(wr_cnt1), chk_t'(1));
        checkOutput("small_wr_addr", chk_t'(wr_addr1_s), chk_t'(0));
        checkOutput("small_tap0", chk_t'(wr_data1_s[15:0]), chk_t'(16'h0201));
        checkOutput("small_tap8", chk_t'(wr_data1_s[143:128]), chk_t'(16'h1211));
        checkOutput("small_word", chk_t'(wr_data1_s), chk_t'(small_word));
        checkOutput("small_done_count", chk_t'(done_cnt1), chk_t'(1));
        checkOutput("small_done_delay", chk_t'(done_cyc1 - wr_cyc1), chk_t'(2));
        checkOutput("small_busy_drop", chk_t'({busy_before_done1, busy_at_done1}), chk_t'(2'b10));
        checkOutput("small_word_cnt", chk_t'(word_cnt1), chk_t'(1));
        mon1_en = 1'b0;

        $display("[TB] full load");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        use_small = 1'b0;
        base_wr   = wr_cnt0;
        base_done = done_cnt0;
        mon0_en   = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("load_start", chk_t'({busy0, in_ready0, word_cnt0}), chk_t'({1'b1, 1'b1, 12'd0}));
        for (int w = 0; w < FULL_WORDS; w++) begin
            randomWord(word);
            sendWord(word, ADDR_W'(w), 1'b1, (w == 0) ? 7 : -1, (w == 3) ? 4 : -1);
        end
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("full_write_count", chk_t'(wr_cnt0 - base_wr), chk_t'(FULL_WORDS));
        checkOutput("full_done_count", chk_t'(done_cnt0 - base_done), chk_t'(1));
        checkOutput("full_queue_empty", chk_t'(exp_q.size()), chk_t'(0));
        checkOutput("full_word_cnt", chk_t'(word_cnt0), chk_t'(FULL_WORDS));
        checkOutput("full_idle_after", chk_t'({busy0, done0, in_ready0}), chk_t'(3'b000));

        $display("[TB] reset in the middle of a word");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        base_wr = wr_cnt0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int w = 0; w < 5; w++) begin
            randomWord(word);
            sendWord(word, ADDR_W'(w), 1'b0, -1, -1);
        end
        randomWord(word);
        for (int b = 0; b < 10; b++) applyStimulus(word[8*b +: 8]);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("pre_reset_state", chk_t'({busy0, wr_en0, word_cnt0}), chk_t'({1'b1, 1'b0, 12'd5}));
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset_clears",
                    chk_t'({in_ready0, wr_en0, busy0, done0, wr_addr0, wr_data0, word_cnt0}), '0);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("restart", chk_t'({busy0, in_ready0, word_cnt0}), chk_t'({1'b1, 1'b1, 12'd0}));
        randomWord(word);
        sendWord(word, ADDR_W'(0), 1'b0, -1, -1);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("reset_queue_empty", chk_t'(exp_q.size()), chk_t'(0));
        checkOutput("reset_write_count", chk_t'(wr_cnt0 - base_wr), chk_t'(6));
        checkOutput("restart_word_cnt", chk_t'(word_cnt0), chk_t'(1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/conv_weight_loader.md
Name: conv_weight_loader

Overview:
- Write-side counterpart of the conv weight reader path.
- Accepts a byte stream over a valid/ready handshake, for example from the host UART receiver.
- Assembles 9-tap kernels of 16-bit fixed-point words and writes them through port B of mem_conv_w, addresses 0..2575 (CONV1 at 0, CONV2 at 16, CONV3 at 528).
- Runs once per start pulse, before inference begins. The read side uses port A.

Parameters:
- WORDS, 2576, number of 144-bit kernel words to write (16 + 512 + 2048).
- PARSIZE, 16, bits per parameter; must equal `PARSIZE.
- TAPS, 9, parameters per kernel word.
- ADDR_W, 12, width of wr_addr.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle request to begin a full load; honoured only in IDLE.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  write strobe to mem_conv_w port B (drives enb and web).
- wr_addr  out  ADDR_W  write address (addrb).
- wr_data  out  TAPS*PARSIZE  write word (dinb).
- busy  out  1  high in RECV and WRITE.
- done  out  1  one-cycle pulse after the last word is written.
- word_cnt  out  ADDR_W  number of words written so far in the current load.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state goes to IDLE.
  - in_ready, wr_en, busy and done go to 0.
  - wr_addr, wr_data, word_cnt, the byte counter and the assembly register go to 0.
- Byte packing: byte b (0..17) of a word goes to wr_data[8b+7:8b].
  - Each 16-bit parameter is therefore little-endian.
  - Tap k occupies wr_data[16k+15:16k].
- Handshake: a byte transfers in a cycle where in_valid && in_ready. in_ready is a registered output and does not depend combinationally on in_valid.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - start=1 moves to RECV; byte counter and word_cnt clear to 0.
- RECV:
  - in_ready=1.
  - Each transfer stores the byte at the current byte index, then increments the index.
  - The transfer of byte 17 moves to WRITE; in_ready is 0 from the next cycle.
  - in_valid low stalls indefinitely with no timeout.
- WRITE:
  - Exactly one cycle with wr_en=1, wr_addr=word_cnt and wr_data=the assembled word.
  - Next cycle: word_cnt increments and the byte index clears.
  - If word_cnt was WORDS-1, move to DONE; otherwise return to RECV.
  - No byte is accepted during WRITE.
- DONE: done=1 for one cycle, then IDLE. word_cnt holds WORDS until the next start or reset.
- Latency and throughput:
  - The first wr_en comes 1 cycle after the transfer of byte 17.
  - Peak throughput is one word per 19 cycles.
- Outside WRITE: wr_en=0. wr_addr and wr_data hold their last values (no glitch requirement on a disabled port).
- Boundary conditions:
  - start while busy or in DONE: ignored; no restart.
  - start and in_valid together in IDLE: the byte is not consumed (in_ready=0 in that cycle).
  - rst_n low mid-word: the partial word is discarded and no write is issued. Words already written stay in memory.
  - in_valid with in_ready=0: no state change; the byte is not consumed.
  - word_cnt never exceeds WORDS; wr_addr never exceeds WORDS-1.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, then release with no start -> all outputs 0, in_ready=0 for 20 cycles.
- Single word:
  - Setup: WORDS=1; start; stream bytes 0x01..0x12 back to back.
  - Exactly one wr_en, with wr_addr=0 and wr_data[15:0]=0x0201, wr_data[143:128]=0x1211.
  - done pulses 2 cycles after the wr_en cycle; busy drops with done.
- Full load:
  - Setup: default WORDS; 46368 random bytes with random in_valid gaps.
  - 2576 writes at addresses 0..2575 in order, each matching the reference model.
  - A single done pulse; word_cnt=2576 afterwards.
- Handshake stall: drop in_valid for 10 cycles after byte 7 -> no writes and no counter change during the gap; the assembled word is still correct.
- Start ignored: pulse start during RECV of word 3 -> addresses continue 3, 4, ...; word_cnt is not cleared.
- Reset mid-word: assert rst_n=0 after byte 9 of word 5, then start again -> no write to address 5 before reset; the new load begins at wr_addr=0 with a fresh byte index.
